// File: rtl/pong_pkg.sv
// Shared types and constants for the pong game-flow referee.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  localparam int DEFAULT_CLK_PER_SEC = 25_000_000;

  // Scores never go past 9 so they always fit one BCD digit.
  function automatic bcd_t bcd_inc_sat(input bcd_t d);
    bcd_t r;
    if (d >= 4'd9) begin
      r = 4'd9;
    end else begin
      r = d + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_countdown.sv
// Two-digit BCD down-counter for the game clock; reloads to START and
// sticks at 00 once reached.
module bcd_countdown
  import pong_pkg::*;
#(
  parameter int START = 60
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output bcd_t tens,
  output bcd_t units,
  output logic zero
);

  localparam bcd_t START_TENS  = bcd_t'(START / 10);
  localparam bcd_t START_UNITS = bcd_t'(START % 10);

  bcd_t tens_r;
  bcd_t units_r;
  logic zero_s;

  assign zero_s = (tens_r == 4'd0) && (units_r == 4'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tens_r  <= START_TENS;
      units_r <= START_UNITS;
    end else if (load) begin
      tens_r  <= START_TENS;
      units_r <= START_UNITS;
    end else if (en && !zero_s) begin
      if (units_r == 4'd0) begin
        units_r <= 4'd9;
        tens_r  <= tens_r - 4'd1;
      end else begin
        units_r <= units_r - 4'd1;
      end
    end else begin
      tens_r  <= tens_r;
      units_r <= units_r;
    end
  end

  assign tens  = tens_r;
  assign units = units_r;
  assign zero  = zero_s;

endmodule

// File: rtl/pong_referee.sv
// Game-flow controller: scores misses, runs the serve freeze and the
// countdown clock, and reports game over with the winner.
module pong_referee
  import pong_pkg::*;
#(
  parameter int CLK_PER_SEC  = DEFAULT_CLK_PER_SEC,
  parameter int GAME_SECONDS = 60,
  parameter int WIN_SCORE    = 5,
  parameter int SERVE_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       miss1,
  input  logic       miss2,
  output logic       stop,
  output logic [3:0] sec1,
  output logic [3:0] sec0,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam int PRE_W = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam int SRV_W = (SERVE_CYCLES > 1) ? $clog2(SERVE_CYCLES) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_SEC - 1);
  localparam logic [SRV_W-1:0] SRV_LAST = SRV_W'(SERVE_CYCLES - 1);
  localparam bcd_t WIN_BCD = bcd_t'(WIN_SCORE);

  state_t           state_r, state_s;
  logic             start_q_r, armed_r, rise_s;
  logic [PRE_W-1:0] pre_r;
  logic [SRV_W-1:0] srv_r;
  logic             tick_s, srv_done_s, expiring_s, timer_load_s;
  bcd_t             sec1_s, sec0_s;
  logic             zero_s;
  bcd_t             score1_r, score2_r, score1_s, score2_s;
  logic             stop_r, stop_s, game_over_r, game_over_s;
  logic [1:0]       winner_r, winner_s;

  // armed_r blocks a start level held through reset from counting as an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_q_r <= 1'b0;
      armed_r   <= 1'b0;
    end else begin
      start_q_r <= start;
      armed_r   <= armed_r | ~start;
    end
  end

  assign rise_s       = start & ~start_q_r & armed_r;
  assign tick_s       = (state_r == ST_PLAY) && (pre_r == PRE_LAST);
  assign srv_done_s   = (state_r == ST_SERVE) && (srv_r == SRV_LAST);
  assign expiring_s   = zero_s || (tick_s && (sec1_s == 4'd0) && (sec0_s == 4'd1));
  assign timer_load_s = (state_r == ST_IDLE) || ((state_r == ST_OVER) && rise_s);

  bcd_countdown #(
    .START(GAME_SECONDS)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load_s),
    .en   (tick_s),
    .tens (sec1_s),
    .units(sec0_s),
    .zero (zero_s)
  );

  always_comb begin
    score1_s = score1_r;
    score2_s = score2_r;
    case (state_r)
      ST_IDLE: begin
        score1_s = 4'd0;
        score2_s = 4'd0;
      end
      ST_PLAY: begin
        if (miss1 && !miss2) begin
          score2_s = bcd_inc_sat(score2_r);
        end else if (miss2 && !miss1) begin
          score1_s = bcd_inc_sat(score1_r);
        end else begin
          score1_s = score1_r;
        end
      end
      ST_OVER: begin
        if (rise_s) begin
          score1_s = 4'd0;
          score2_s = 4'd0;
        end else begin
          score1_s = score1_r;
        end
      end
      default: begin
        score1_s = score1_r;
        score2_s = score2_r;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // A winning score takes priority over both timer expiry and re-serve.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (rise_s) state_s = ST_SERVE;
        else        state_s = ST_IDLE;
      end
      ST_SERVE: begin
        if (srv_done_s) state_s = ST_PLAY;
        else            state_s = ST_SERVE;
      end
      ST_PLAY: begin
        if ((score1_s == WIN_BCD) || (score2_s == WIN_BCD)) state_s = ST_OVER;
        else if (expiring_s)                               state_s = ST_OVER;
        else if (miss1 || miss2)                           state_s = ST_SERVE;
        else                                               state_s = ST_PLAY;
      end
      ST_OVER: begin
        if (rise_s) state_s = ST_SERVE;
        else        state_s = ST_OVER;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  always_comb begin
    stop_s      = (state_s != ST_PLAY);
    game_over_s = (state_s == ST_OVER);
    winner_s    = WIN_NONE;
    if (state_s == ST_OVER) begin
      if (score1_s > score2_s)      winner_s = WIN_P1;
      else if (score2_s > score1_s) winner_s = WIN_P2;
      else                          winner_s = WIN_TIE;
    end else begin
      winner_s = WIN_NONE;
    end
  end

  // Both counters restart on every state entry, so game time pauses in SERVE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_r <= '0;
      srv_r <= '0;
    end else begin
      if ((state_r == ST_PLAY) && (state_s == ST_PLAY)) begin
        pre_r <= tick_s ? '0 : pre_r + PRE_W'(1);
      end else begin
        pre_r <= '0;
      end
      if ((state_r == ST_SERVE) && (state_s == ST_SERVE)) begin
        srv_r <= srv_r + SRV_W'(1);
      end else begin
        srv_r <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      score1_r    <= 4'd0;
      score2_r    <= 4'd0;
      stop_r      <= 1'b1;
      game_over_r <= 1'b0;
      winner_r    <= WIN_NONE;
    end else begin
      score1_r    <= score1_s;
      score2_r    <= score2_s;
      stop_r      <= stop_s;
      game_over_r <= game_over_s;
      winner_r    <= winner_s;
    end
  end

  assign stop      = stop_r;
  assign sec1      = sec1_s;
  assign sec0      = sec0_s;
  assign score1    = score1_r;
  assign score2    = score2_r;
  assign game_over = game_over_r;
  assign winner    = winner_r;

endmodule

// File: tb/tb_pong_referee.sv
// Scoreboard bench for pong_referee: a behavioural game model queues the
// expected outputs for each cycle and they are compared after the edge.
module tb_pong_referee;

  localparam int CPS = 4;
  localparam int SC  = 3;
  localparam int GS  = 12;
  localparam int WS  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       miss1 = 1'b0;
  logic       miss2 = 1'b0;
  logic       stop, game_over;
  logic [3:0] sec1, sec0, score1, score2;
  logic [1:0] winner;

  pong_referee #(
    .CLK_PER_SEC (CPS),
    .GAME_SECONDS(GS),
    .WIN_SCORE   (WS),
    .SERVE_CYCLES(SC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .miss1    (miss1),
    .miss2    (miss2),
    .stop     (stop),
    .sec1     (sec1),
    .sec0     (sec0),
    .score1   (score1),
    .score2   (score2),
    .game_over(game_over),
    .winner   (winner)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       stop;
    logic [3:0] sec1;
    logic [3:0] sec0;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       go;
    logic [1:0] win;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // model state: 0 idle, 1 serve, 2 play, 3 over
  int mst, ms1, ms2, mt, mpre, msrv;
  bit mq, marm;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mst = 0; ms1 = 0; ms2 = 0; mt = GS; mpre = 0; msrv = 0;
    mq = 1'b0; marm = 1'b0;
    exp_q.delete();
  endtask

  task automatic step(input logic s, input logic m1, input logic m2);
    bit   rise, tick;
    int   ns, n1, n2, nt;
    exp_t e;
    rise = s && !mq && marm;
    ns = mst; n1 = ms1; n2 = ms2; nt = mt; tick = 1'b0;
    case (mst)
      0: begin
        n1 = 0; n2 = 0; nt = GS;
        if (rise) ns = 1;
      end
      1: if (msrv == SC - 1) ns = 2;
      2: begin
        tick = (mpre == CPS - 1);
        if (tick && nt > 0) nt = nt - 1;
        if (m1 && !m2 && n2 < 9) n2 = n2 + 1;
        if (m2 && !m1 && n1 < 9) n1 = n1 + 1;
        if (n1 >= WS || n2 >= WS || nt == 0) ns = 3;
        else if (m1 || m2) ns = 1;
      end
      default: if (rise) begin
        ns = 1; n1 = 0; n2 = 0; nt = GS;
      end
    endcase
    mpre = (mst == 2 && ns == 2) ? (tick ? 0 : mpre + 1) : 0;
    msrv = (mst == 1 && ns == 1) ? msrv + 1 : 0;
    mq = s;
    marm = marm | !s;
    mst = ns; ms1 = n1; ms2 = n2; mt = nt;
    e.stop = (ns != 2);
    e.sec1 = 4'(nt / 10);
    e.sec0 = 4'(nt % 10);
    e.s1   = 4'(n1);
    e.s2   = 4'(n2);
    e.go   = (ns == 3);
    e.win  = (ns != 3) ? 2'b00 : (n1 > n2) ? 2'b01 : (n2 > n1) ? 2'b10 : 2'b11;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic s, input logic m1, input logic m2);
    exp_t e;
    start = s; miss1 = m1; miss2 = m2;
    step(s, m1, m2);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_val("stop",      32'(stop),      32'(e.stop));
    check_val("sec1",      32'(sec1),      32'(e.sec1));
    check_val("sec0",      32'(sec0),      32'(e.sec0));
    check_val("score1",    32'(score1),    32'(e.s1));
    check_val("score2",    32'(score2),    32'(e.s2));
    check_val("game_over", 32'(game_over), 32'(e.go));
    check_val("winner",    32'(winner),    32'(e.win));
  endtask

  task automatic run_until_play();
    int n = 0;
    while (mst != 2 && n < 20) begin
      cyc(1'b0, 1'b0, 1'b0);
      n++;
    end
    check_val("reach_play", 32'(mst == 2), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_stop"},   32'(stop),      32'd1);
    check_val({tag, "_sec1"},   32'(sec1),      32'd1);
    check_val({tag, "_sec0"},   32'(sec0),      32'd2);
    check_val({tag, "_score1"}, 32'(score1),    32'd0);
    check_val({tag, "_score2"}, 32'(score2),    32'd0);
    check_val({tag, "_go"},     32'(game_over), 32'd0);
    check_val({tag, "_win"},    32'(winner),    32'd0);
  endtask

  initial begin
    int n;
    model_reset();
    #12;
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b1;

    // first serve and first timer decrement
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b0, 1'b0);
    check_val("first_tick_sec0", 32'(sec0), 32'd1);

    // miss2 held for two cycles scores once
    run_until_play();
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    check_val("held_miss_score1", 32'(score1), 32'd1);
    run_until_play();

    // player 2 wins on three misses by player 1
    for (int i = 0; i < 3; i++) begin
      run_until_play();
      cyc(1'b0, 1'b1, 1'b0);
    end
    check_val("p2_win_winner", 32'(winner), 32'd2);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    check_val("over_ignores_miss", 32'(score2), 32'd3);

    // full timeout with no points is a tie
    cyc(1'b1, 1'b0, 1'b0);
    n = 0;
    while (mst != 3 && n < 80) begin
      cyc(1'b0, 1'b0, 1'b0);
      n++;
    end
    check_val("timeout_reached", 32'(mst == 3), 32'd1);
    check_val("timeout_tie", 32'(winner), 32'd3);

    // simultaneous misses, then a miss on the expiry cycle
    cyc(1'b1, 1'b0, 1'b0);
    run_until_play();
    cyc(1'b0, 1'b1, 1'b1);
    n = 0;
    while (!(mst == 2 && mt == 1 && mpre == CPS - 1) && n < 200) begin
      cyc(1'b0, 1'b0, 1'b0);
      n++;
    end
    check_val("expiry_cycle_found", 32'(mst == 2 && mt == 1), 32'd1);
    cyc(1'b0, 1'b1, 1'b0);
    check_val("expiry_miss_score2", 32'(score2), 32'd1);
    check_val("expiry_miss_winner", 32'(winner), 32'd2);

    // build 2-1 with timer at 07, then reset mid-play
    cyc(1'b1, 1'b0, 1'b0);
    run_until_play();
    cyc(1'b0, 1'b0, 1'b1);
    run_until_play();
    cyc(1'b0, 1'b0, 1'b1);
    run_until_play();
    cyc(1'b0, 1'b1, 1'b0);
    run_until_play();
    n = 0;
    while (mt != 7 && n < 100) begin
      cyc(1'b0, 1'b0, 1'b0);
      n++;
    end
    check_val("pre_reset_sec0", 32'(sec0), 32'd7);
    check_val("pre_reset_score1", 32'(score1), 32'd2);
    #2;
    rst = 1'b0;
    start = 1'b1;
    #1;
    check_reset_outputs("async");
    @(posedge clk);
    #1;
    check_reset_outputs("held");
    @(negedge clk);
    rst = 1'b1;
    model_reset();

    // start held through release must not start a game
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    run_until_play();
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
